apb5_completer_mem: RTL
=======================

Name: apb5_completer_mem

Overview:
APB5 completer (slave) endpoint: a small word-addressed memory with per-word user-data storage, programmable wait states and error responses. It is the responding end of the APB5 interface driven by the requester VIP. It serves as the DUT-side responder in back-to-back benches and as a reference completer for protocol checks.

Parameters:
ADDR_WIDTH, 8, PADDR width in bits.
DATA_WIDTH, 8, PWDATA/PRDATA width; one of 8, 16 or 32.
DEPTH, 16, number of data words; must be at most 2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
SECURE_WORDS, 4, words 0..SECURE_WORDS-1 are secure-only.
USER_REQ_WIDTH, 8, PAUSER width.
USER_DATA_WIDTH, 16, PWUSER/PRUSER width.
USER_RESP_WIDTH, 8, PBUSER width.

Ports:
PCLK  input  1  clock; all logic on the rising edge.
PRESETN  input  1  asynchronous active-low reset.
PSEL  input  1  select.
PENABLE  input  1  access phase.
PADDR  input  ADDR_WIDTH  byte address.
PWRITE  input  1  1 = write.
PWDATA  input  DATA_WIDTH  write data.
PSTRB  input  DATA_WIDTH/8  byte write strobes.
PPROT  input  3  protection; PPROT[1]=1 means non-secure.
PAUSER  input  USER_REQ_WIDTH  request user bits.
PWUSER  input  USER_DATA_WIDTH  write user bits.
cfg_wait  input  4  wait states for the next transfer; sampled in the setup phase.
PRDATA  output  DATA_WIDTH  read data.
PRUSER  output  USER_DATA_WIDTH  read user bits.
PBUSER  output  USER_RESP_WIDTH  response user bits.
PREADY  output  1  transfer complete.
PSLVERR  output  1  error response.
proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer): FSM goes to IDLE; PREADY, PSLVERR and proto_err = 0; PRDATA, PRUSER and PBUSER = 0; all memory and user words cleared to 0.
- Word index = PADDR >> log2(DATA_WIDTH/8). Low byte-offset bits are ignored.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: when PSEL=1 and PENABLE=0 (setup phase), latch the address, direction, PPROT, the error decision, PAUSER and cfg_wait into cnt. Go to WAIT if cnt>0, else RESP.
  - WAIT: PREADY=0. Decrement cnt each cycle. When cnt reaches 1, go to RESP.
  - RESP: PREADY=1 for exactly one cycle, then go to IDLE. Back-to-back transfers are allowed: the next setup phase follows immediately.
- Latency: PREADY rises cfg_wait+1 cycles after the setup-phase edge. A cfg_wait of 0 gives a zero-wait access.
- PREADY is a registered output.
- Error (PSLVERR=1 in the RESP cycle) on either condition:
  - word index >= DEPTH;
  - PPROT[1]=1 and word index < SECURE_WORDS.
- On error: no write occurs, and PRDATA and PRUSER = 0.
- Write commit happens in the RESP cycle when there is no error:
  - each byte lane i is written only when PSTRB[i]=1;
  - the per-word user store is written with PWUSER when any PSTRB bit is set;
  - PSTRB=0 is a legal no-op that completes with OKAY.
- Read: PRDATA and PRUSER present the stored word only in the RESP cycle and are 0 otherwise. PSTRB is ignored for completion purposes.
- PBUSER = PAUSER latched at setup, truncated or zero-extended to USER_RESP_WIDTH; driven in the RESP cycle only, else 0.
- PSLVERR is 0 outside the RESP cycle.
- proto_err sets and holds until reset on any of:
  - PENABLE=1 in IDLE without a preceding setup phase;
  - PADDR, PWRITE or PWDATA changing during WAIT;
  - PSEL dropping during WAIT;
  - PSTRB != 0 on a read.
- If PSEL drops during WAIT, the FSM also aborts to IDLE with no write.

Optional Feature:
APB5_RME_EN:
- Defined: adds input PNSE (1 bit), latched at setup together with PPROT. The combination {PNSE=1, PPROT[1]=0} (Root/Realm tag) is an additional PSLVERR condition, with no write and zero read data.
- Not defined: port PNSE is absent and RME checks are omitted.

Test Plan:
1. Reset, then write 0xA5 to 0x05 with PSTRB=1, cfg_wait=0, PPROT=3'b010 -> PREADY in the cycle after setup, PSLVERR=0; a subsequent read of 0x05 returns 0xA5 and the PWUSER value.
2. cfg_wait=3, read 0x05 -> PREADY low for 3 access cycles, then high for exactly 1 cycle with PRDATA=0xA5.
3. DATA_WIDTH=32: write 0x11223344 with PSTRB=4'b0101 over a word holding 0 -> readback 0x00220044.
4. Read 0x20 (index 32 >= 16), and a write to 0x01 with PPROT[1]=1 -> both give PSLVERR=1 and PRDATA=0; word 0x01 is unchanged.
5. PSEL dropped during WAIT -> proto_err=1 and stays high, FSM returns to IDLE, no write occurs; PRESETN pulse mid-WAIT -> PREADY=0 and memory reads back 0.
6. APB5_RME_EN defined: PNSE=1, PPROT[1]=0 write to 0x08 -> PSLVERR=1; PNSE=1, PPROT[1]=1 write to 0x08 -> OKAY.

Source files
------------

// File: rtl/apb5_completer_mem.sv
`default_nettype none
// ============================================================================
// Module   : apb5_completer_mem
// Brief    : APB5 completer backed by a word memory with per-word user data,
//            programmable wait states, error responses and a sticky protocol
//            violation flag. Define APB5_RME_EN to add the PNSE input.
// Revision : 1.0 - initial release
// ============================================================================
module apb5_completer_mem #(
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int DEPTH           = 16,
  parameter int SECURE_WORDS    = 4,
  parameter int USER_REQ_WIDTH  = 8,
  parameter int USER_DATA_WIDTH = 16,
  parameter int USER_RESP_WIDTH = 8
) (
  input  logic                         PCLK,
  input  logic                         PRESETN,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic [ADDR_WIDTH-1:0]        PADDR,
  input  logic                         PWRITE,
  input  logic [DATA_WIDTH-1:0]        PWDATA,
  input  logic [DATA_WIDTH/8-1:0]      PSTRB,
  input  logic [2:0]                   PPROT,
  input  logic [USER_REQ_WIDTH-1:0]    PAUSER,
  input  logic [USER_DATA_WIDTH-1:0]   PWUSER,
`ifdef APB5_RME_EN
  input  logic                         PNSE,
`endif
  input  logic [3:0]                   cfg_wait,
  output logic [DATA_WIDTH-1:0]        PRDATA,
  output logic [USER_DATA_WIDTH-1:0]   PRUSER,
  output logic [USER_RESP_WIDTH-1:0]   PBUSER,
  output logic                         PREADY,
  output logic                         PSLVERR,
  output logic                         proto_err
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam int MW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic [DATA_WIDTH-1:0]      r_mem  [DEPTH];
  logic [USER_DATA_WIDTH-1:0] r_user [DEPTH];
  logic [MW-1:0]              r_idx;
  logic [3:0]                 r_cnt;
  logic [ADDR_WIDTH-1:0]      r_addr;
  logic [DATA_WIDTH-1:0]      r_wdata;
  logic [USER_RESP_WIDTH-1:0] r_buser;
  logic                       r_write, r_err, r_pready, r_proto;

  logic [31:0]                w_idx;
  logic [USER_RESP_WIDTH-1:0] w_buser;
  logic                       w_setup, w_err, w_rme_err, w_viol, w_rd_ok, w_unused;

  assign w_setup = PSEL & ~PENABLE;
  assign w_idx   = 32'(PADDR) >> OFFS;

`ifdef APB5_RME_EN
  // Root/Realm tag: PNSE set while PPROT marks the access secure
  assign w_rme_err = PNSE & ~PPROT[1];
`else
  assign w_rme_err = 1'b0;
`endif

  assign w_err = (w_idx >= DEPTH) | (PPROT[1] & (w_idx < SECURE_WORDS)) | w_rme_err;

  generate
    if (USER_RESP_WIDTH > USER_REQ_WIDTH) begin : g_buser_ext
      assign w_buser = {{(USER_RESP_WIDTH-USER_REQ_WIDTH){1'b0}}, PAUSER};
    end else begin : g_buser_trunc
      assign w_buser = PAUSER[USER_RESP_WIDTH-1:0];
    end
  endgenerate

  assign w_viol = ((r_state == S_IDLE) & PSEL & PENABLE)
                | ((r_state == S_IDLE) & w_setup & ~PWRITE & (PSTRB != '0))
                | ((r_state == S_WAIT) & (~PSEL | (PADDR != r_addr) |
                                          (PWRITE != r_write) | (PWDATA != r_wdata)));

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_setup) w_next = (cfg_wait != 4'd0) ? S_WAIT : S_RESP;
      S_WAIT: begin
        if (!PSEL)              w_next = S_IDLE;
        else if (r_cnt == 4'd1) w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_idx    <= '0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_buser  <= '0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_pready <= 1'b0;
      r_proto  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i]  <= '0;
        r_user[i] <= '0;
      end
    end else begin
      r_pready <= (w_next == S_RESP);
      r_proto  <= r_proto | w_viol;
      if ((r_state == S_IDLE) && w_setup) begin
        r_idx   <= w_idx[MW-1:0];
        r_cnt   <= cfg_wait;
        r_addr  <= PADDR;
        r_wdata <= PWDATA;
        r_buser <= w_buser;
        r_write <= PWRITE;
        r_err   <= w_err;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Commit happens on the completing edge so an aborted transfer never writes
      if ((r_state == S_RESP) && r_write && !r_err) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (PSTRB[b]) r_mem[r_idx][8*b +: 8] <= PWDATA[8*b +: 8];
        end
        if (PSTRB != '0) r_user[r_idx] <= PWUSER;
      end
    end
  end

  assign w_rd_ok   = r_pready & ~r_err & ~r_write;
  assign PREADY    = r_pready;
  assign PSLVERR   = r_pready & r_err;
  assign PRDATA    = w_rd_ok ? r_mem[r_idx]  : '0;
  assign PRUSER    = w_rd_ok ? r_user[r_idx] : '0;
  assign PBUSER    = r_pready ? r_buser : '0;
  assign proto_err = r_proto;

  assign w_unused  = &{1'b0, PPROT[2], PPROT[0]};

endmodule
`default_nettype wire
